regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (WriteEnable/RegWrite/DataWrite) between two sources:
//  - Source A: the in-order pipeline writeback stage.
//  - Source B: a multi-cycle unit (mul/div, late loads), buffered in a DEPTH-entry FIFO.
//  A has priority. B is protected from starvation by a wait counter.
//  Exports pending_mask so hazard logic can stall readers of registers with queued writes.
// PARAMETERS
//  DEPTH         4   B-side FIFO entries; power of 2, >=2
//  STARVE_LIMIT  8   cycles a B head may wait before A is refused for one cycle; >=1
// PORTS
//  CLOCK         in   1   clock, rising edge
//  RESET         in   1   asynchronous, active-high reset
//  a_valid       in   1   A write request
//  a_ready       out  1   A accepted on this edge when a_valid & a_ready
//  a_addr        in   5   A destination register
//  a_data        in   32  A write data
//  b_valid       in   1   B write request
//  b_ready       out  1   B FIFO not full
//  b_addr        in   5   B destination register
//  b_data        in   32  B write data
//  WriteEnable   out  1   register-file write enable (registered)
//  RegWrite      out  5   register-file write address (registered)
//  DataWrite     out  32  register-file write data (registered)
//  pending_mask  out  32  bit i = some valid FIFO entry targets register i (bit 0 always 0)
//  fifo_count    out  clog2(DEPTH)+1  number of valid FIFO entries
// BEHAVIOUR
//  Reset: asynchronous. FIFO emptied, wait counter 0, WriteEnable 0, RegWrite 0, DataWrite 0.
//    While RESET is high: a_ready=0, b_ready=0. Queued entries are discarded, never written.
//  B push: b_valid & b_ready on an edge writes the tail entry.
//    b_ready = !full (no pass-through when full).
//    An entry pushed at edge t is head-eligible from cycle t+1.
//  Grant, each cycle, combinational:
//    - starve = fifo nonempty & (wait_cnt == STARVE_LIMIT).
//    - a_ready = !starve.
//    - grant_B = fifo nonempty & (starve | !a_valid).
//    - grant_A = a_valid & a_ready.
//    - grant_A and grant_B are never both 1.
//  Wait counter:
//    - Cleared when FIFO empty or on grant_B.
//    - Otherwise increments when the head is not granted.
//    - Saturates at STARVE_LIMIT.
//  Output stage: the granted write is registered at the edge and drives the write port for exactly one cycle.
//    Latency is 1 cycle from accept/grant edge to WriteEnable.
//    With no grant: WriteEnable=0; RegWrite/DataWrite hold their last value.
//  r0: writes with addr 0 are accepted and popped normally, but WriteEnable stays 0. Address 0 never sets pending_mask.
//  Simultaneous push and pop (not full): both occur; count unchanged. Pop when empty never happens.
//  Pointers wrap modulo DEPTH. FIFO order is preserved; B entries never reorder among themselves.
//  Cross-source WAW ordering is the issuer's job, using pending_mask. The arbiter does not compare A vs B addresses.
//  pending_mask and fifo_count are combinational from FIFO state. Both reflect the state after the last edge.
// TESTING
//  1. Reset: pulse RESET mid-cycle, no clock -> WriteEnable=0, pending_mask=0, fifo_count=0. After release, a_ready=1 and b_ready=1.
//  2. A only: a_valid, addr 5, data 0xDEADBEEF at edge t -> cycle t+1: WriteEnable=1, RegWrite=5, DataWrite=0xDEADBEEF. Cycle t+2: WriteEnable=0.
//  3. Fill: A valid every cycle, push B addr 1,2,3,4 -> b_ready=0 after 4th push, fifo_count=4, pending_mask=0x0000001E.
//  4. Starvation: A valid every cycle, one B entry (addr 7, data 0x77) head-eligible at cycle h ->
//     a_ready=0 only in cycle h+8; WriteEnable with RegWrite=7 in cycle h+9; pending_mask=0 afterward.
//  5. B drains when A idle: 3 entries, a_valid=0 -> WriteEnable on 3 consecutive cycles in push order; fifo_count reaches 0.
//  6. r0 and reset mid-op:
//     - A and B writes to addr 0 -> accepted, WriteEnable never 1, pending_mask bit 0 = 0.
//     - With 3 queued entries, pulse RESET -> fifo_count=0 and no queued write ever appears on the port.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback (A, priority)
// and a FIFO-buffered multi-cycle unit (B), with starvation protection and a pending-register mask.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [4:0]                a_addr,
    input  logic [31:0]               a_data,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [4:0]                b_addr,
    input  logic [31:0]               b_data,
    output logic                      WriteEnable,
    output logic [4:0]                RegWrite,
    output logic [31:0]               DataWrite,
    output logic [31:0]               pending_mask,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wait_cnt;
    logic          r_write_enable;
    logic [4:0]    r_reg_write;
    logic [31:0]   r_data_write;

    logic w_empty;
    logic w_full;
    logic w_starve;
    logic w_grant_a;
    logic w_grant_b;
    logic w_push;

    // Grant logic: A wins unless the B head has waited STARVE_LIMIT cycles.
    assign w_empty   = (r_count == CW'(0));
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_starve  = !w_empty && (r_wait_cnt == WW'(STARVE_LIMIT));
    assign a_ready   = !RESET && !w_starve;
    assign b_ready   = !RESET && !w_full;
    assign w_grant_b = !w_empty && (w_starve || !a_valid);
    assign w_grant_a = a_valid && a_ready;
    assign w_push    = b_valid && b_ready;

    assign WriteEnable = r_write_enable;
    assign RegWrite    = r_reg_write;
    assign DataWrite   = r_data_write;
    assign fifo_count  = r_count;

    // Registers targeted by any live FIFO entry; r0 is never reported.
    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_fifo_addr[r_rd_ptr + AW'(i)] != 5'd0)) begin
                pending_mask[r_fifo_addr[r_rd_ptr + AW'(i)]] = 1'b1;
            end
        end
    end

    // FIFO storage carries no reset; validity comes from r_count.
    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= b_addr;
            r_fifo_data[r_wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_wait_cnt     <= '0;
            r_write_enable <= 1'b0;
            r_reg_write    <= '0;
            r_data_write   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_grant_b) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_grant_b})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_empty || w_grant_b) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WW'(STARVE_LIMIT)) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end

            // Writes to r0 are consumed but never enable the port.
            if (w_grant_a) begin
                r_write_enable <= (a_addr != 5'd0);
                r_reg_write    <= a_addr;
                r_data_write   <= a_data;
            end else if (w_grant_b) begin
                r_write_enable <= (r_fifo_addr[r_rd_ptr] != 5'd0);
                r_reg_write    <= r_fifo_addr[r_rd_ptr];
                r_data_write   <= r_fifo_data[r_rd_ptr];
            end else begin
                r_write_enable <= 1'b0;
            end
        end
    end
endmodule
